rf_writeback: RTL and testbench
===============================

Name: rf_writeback

Overview:
- Writeback stage feeding the 32x32 register file write port (Din, WA, RegWrite).
- Accepts completed instructions from the MEM stage over a valid/ready handshake.
- Selects the ALU result or the memory load data, and queues the results in a small FIFO.
- Retires at most one register write per cycle. Exposes a read-port bypass lookup so decode sees pending writes before they land in the register file.

Parameters:
- DEPTH, 2, number of queued writeback entries; power of two, 2..8.
- CNT_W, 16, width of the retired-write counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  MEM stage offers a result
- in_ready  output  1  block can accept this cycle
- in_regwrite  input  1  instruction writes a register
- in_memtoreg  input  1  1 = take in_mem, 0 = take in_alu
- in_wa  input  5  destination register
- in_alu  input  32  ALU result
- in_mem  input  32  load data
- rf_stall  input  1  register-file write port busy this cycle
- Din  output  32  write data to register file
- WA  output  5  write address to register file
- RegWrite  output  1  write strobe to register file
- RA1  input  5  decode read address 1
- RA2  input  5  decode read address 2
- byp1_hit  output  1  RA1 matches a queued entry
- byp1_data  output  32  data of youngest match for RA1
- byp2_hit  output  1  RA2 matches a queued entry
- byp2_data  output  32  data of youngest match for RA2
- pending  output  $clog2(DEPTH)+1  queued entry count
- retired  output  CNT_W  total writes issued

Behaviour:
- Reset (async, rst=1): FIFO empty, pending=0, retired=0. RegWrite=0, Din=0, WA=0, byp*_hit=0, byp*_data=0. in_ready=0 while rst is high.
- Accept: a transfer occurs when in_valid && in_ready at a rising edge.
- in_ready = !full. There is no same-cycle pass-through when full, even if a pop occurs.
- Filter on accept:
  - If in_regwrite=0 or in_wa=0, the transfer completes but nothing is enqueued, because $zero is never written.
  - Otherwise enqueue {wa, data}, where data = in_memtoreg ? in_mem : in_alu, selected at accept time.
- Issue (combinational from the head entry):
  - RegWrite = !empty && !rf_stall.
  - WA and Din = head fields when !empty, else 0.
  - Pop at the edge where RegWrite=1.
- Latency: an accepted entry into an empty FIFO drives RegWrite on the next cycle (1 cycle), unless stalled.
- Simultaneous push and pop: allowed when not full; pending is unchanged.
- Empty FIFO: push only.
- rf_stall held: the head is held; the FIFO fills; in_ready drops at DEPTH entries.
- Bypass lookup (combinational):
  - Scan valid entries for wa==RAx; report the youngest match (last enqueued).
  - RAx=0 never hits.
  - No hit: data=0.
  - An entry being popped this cycle still reports a hit, because the register file has not yet updated for a combinational read.
- Counter: retired increments on each pop and wraps modulo 2^CNT_W.
- Pointers: rd/wr pointers wrap modulo DEPTH; full/empty distinguished by count.
- Reset mid-operation: all queued writes are discarded, and RegWrite falls immediately (async).

Decomposition:
- Shared package: constants REG_W=32, ADDR_W=5, ZERO_REG=5'd0; typedef wb_entry_t {logic [4:0] wa; logic [31:0] data}.
- One natural sub-module: wb_fifo, a parameterised DEPTH FIFO of wb_entry_t exposing its entry array and valid mask for the bypass scan.
- Bypass priority logic stays in rf_writeback.

Test Plan:
- Reset then single write: in_valid=1, regwrite=1, memtoreg=0, wa=5, alu=0x0000_00AA -> next cycle RegWrite=1, WA=5, Din=0xAA; retired=1 after that edge.
- Load select: memtoreg=1, wa=9, alu=0x1, mem=0xDEAD_BEEF -> Din=0xDEADBEEF, WA=9.
- $zero and no-write filter: wa=0 with regwrite=1, then wa=7 with regwrite=0 -> both accepted (in_ready=1), RegWrite never asserts, pending stays 0.
- Stall fill: rf_stall=1, push wa=1 (data 0x11) then wa=2 (data 0x22) -> pending=2, in_ready=0. Release stall -> writes issue in order 1 then 2 on consecutive cycles; in_ready=1 after the first pop.
- Bypass youngest-wins: stall, queue wa=3/0x33 then wa=3/0x44, RA1=3, RA2=0 -> byp1_hit=1, byp1_data=0x44, byp2_hit=0.
- Async reset mid-queue: pending=2, assert rst between edges -> RegWrite=0, pending=0, byp hits 0 immediately. After release, no stale writes issue.

Source files
------------

// File: rtl/rf_writeback_pkg.sv
// Shared types and constants for the register-file writeback stage.
package rf_writeback_pkg;

  localparam int REG_W  = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  // One queued register write: destination and its data.
  typedef struct packed {
    logic [ADDR_W-1:0] wa;
    logic [REG_W-1:0]  data;
  } wb_entry_t;

  // Result mux: load data or ALU result.
  function automatic logic [REG_W-1:0] wb_select(
    input logic             memtoreg,
    input logic [REG_W-1:0] alu,
    input logic [REG_W-1:0] mem
  );
    return memtoreg ? mem : alu;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of writeback entries. Exposes its storage, the
// per-slot valid mask and the head pointer so the owner can scan queued
// writes in age order.
module wb_fifo
  import rf_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  wb_entry_t                    wdata,
  output wb_entry_t                    head,
  output wb_entry_t [DEPTH-1:0]        entries,
  output logic [DEPTH-1:0]             valid,
  output logic [$clog2(DEPTH)-1:0]     head_ptr,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head     = mem[rd_ptr];
  assign entries  = mem;
  assign head_ptr = rd_ptr;

  // Storage needs no reset: slots are only observed through the valid mask.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tells full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = (CW'(PTR_W'(i) - rd_ptr) < count);
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// Writeback stage: accepts MEM-stage results, drops writes to $zero,
// queues the rest and retires one register-file write per cycle. Decode
// can look up queued writes through two bypass ports.
module rf_writeback
  import rf_writeback_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_regwrite,
  input  logic                     in_memtoreg,
  input  logic [4:0]               in_wa,
  input  logic [31:0]              in_alu,
  input  logic [31:0]              in_mem,
  input  logic                     rf_stall,
  output logic [31:0]              Din,
  output logic [4:0]               WA,
  output logic                     RegWrite,
  input  logic [4:0]               RA1,
  input  logic [4:0]               RA2,
  output logic                     byp1_hit,
  output logic [31:0]              byp1_data,
  output logic                     byp2_hit,
  output logic [31:0]              byp2_data,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [CNT_W-1:0]         retired
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int NPORT = 2;

  wb_entry_t               wdata;
  wb_entry_t               head;
  wb_entry_t [DEPTH-1:0]   entries;
  logic [DEPTH-1:0]        valid;
  logic [PTR_W-1:0]        head_ptr;
  logic                    full;
  logic                    empty;
  logic                    accept;
  logic                    push;
  logic                    pop;

  logic [NPORT-1:0][ADDR_W-1:0] ra_vec;
  logic [NPORT-1:0]             hit_vec;
  logic [NPORT-1:0][REG_W-1:0]  data_vec;

  // No pass-through when full, and nothing accepted while reset is held.
  assign in_ready = !full && !rst;
  assign accept   = in_valid && in_ready;
  // $zero and non-writing instructions complete without occupying a slot.
  assign push     = accept && in_regwrite && (in_wa != ZERO_REG);
  assign wdata    = '{wa: in_wa, data: wb_select(in_memtoreg, in_alu, in_mem)};

  assign RegWrite = !empty && !rf_stall;
  assign pop      = RegWrite;
  assign WA       = empty ? '0 : head.wa;
  assign Din      = empty ? '0 : head.data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wdata    (wdata),
    .head     (head),
    .entries  (entries),
    .valid    (valid),
    .head_ptr (head_ptr),
    .count    (pending),
    .full     (full),
    .empty    (empty)
  );

  assign ra_vec[0] = RA1;
  assign ra_vec[1] = RA2;

  // Bypass scan, oldest to youngest so the last enqueued match wins.
  // The head still reports while popping: the RF write has not landed yet.
  for (genvar p = 0; p < NPORT; p++) begin : g_byp
    always_comb begin
      logic [PTR_W-1:0] idx;
      hit_vec[p]  = 1'b0;
      data_vec[p] = '0;
      idx         = '0;
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_ptr + PTR_W'(k);
        if (valid[idx] && ra_vec[p] != ZERO_REG && entries[idx].wa == ra_vec[p]) begin
          hit_vec[p]  = 1'b1;
          data_vec[p] = entries[idx].data;
        end
      end
    end
  end

  assign byp1_hit  = hit_vec[0];
  assign byp1_data = data_vec[0];
  assign byp2_hit  = hit_vec[1];
  assign byp2_data = data_vec[1];

  // Count every write issued to the register file; wraps freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      retired <= '0;
    else if (pop) retired <= retired + 1'b1;
  end

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: each task drives one scenario and checks
// outputs #1 after the rising edge against hand-computed values.
module tb_rf_writeback;

  logic        clk, rst;
  logic        in_valid, in_ready, in_regwrite, in_memtoreg;
  logic [4:0]  in_wa;
  logic [31:0] in_alu, in_mem;
  logic        rf_stall;
  logic [31:0] Din;
  logic [4:0]  WA;
  logic        RegWrite;
  logic [4:0]  RA1, RA2;
  logic        byp1_hit, byp2_hit;
  logic [31:0] byp1_data, byp2_data;
  logic [1:0]  pending;
  logic [15:0] retired;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_ret = '0;

  rf_writeback #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_regwrite(in_regwrite),
    .in_memtoreg(in_memtoreg), .in_wa(in_wa), .in_alu(in_alu), .in_mem(in_mem),
    .rf_stall(rf_stall), .Din(Din), .WA(WA), .RegWrite(RegWrite),
    .RA1(RA1), .RA2(RA2),
    .byp1_hit(byp1_hit), .byp1_data(byp1_data),
    .byp2_hit(byp2_hit), .byp2_data(byp2_data),
    .pending(pending), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic rw, input logic m2r, input logic [4:0] wa,
                       input logic [31:0] alu, input logic [31:0] mem);
    in_valid = 1'b1; in_regwrite = rw; in_memtoreg = m2r;
    in_wa = wa; in_alu = alu; in_mem = mem;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
    total++; if (Din !== 32'h0) begin bad++; $display("FAIL reset_din got=%h exp=0", Din); end
    total++; if (WA !== 5'd0) begin bad++; $display("FAIL reset_wa got=%0d exp=0", WA); end
    total++; if (pending !== 2'd0) begin bad++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    total++; if (retired !== 16'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (byp1_hit !== 1'b0 || byp2_hit !== 1'b0) begin bad++; $display("FAIL reset_byp got=%b%b exp=00", byp1_hit, byp2_hit); end
    tick();
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    offer(1'b1, 1'b0, 5'd5, 32'h0000_00AA, 32'h0);
    tick();
    in_valid = 1'b0;
    total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL single_regwrite got=%b exp=1", RegWrite); end
    total++; if (WA !== 5'd5) begin bad++; $display("FAIL single_wa got=%0d exp=5", WA); end
    total++; if (Din !== 32'h0000_00AA) begin bad++; $display("FAIL single_din got=%h exp=000000aa", Din); end
    total++; if (pending !== 2'd1) begin bad++; $display("FAIL single_pending got=%0d exp=1", pending); end
    tick(); exp_ret++;
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL single_retired got=%0d exp=%0d", retired, exp_ret); end
    total++; if (RegWrite !== 1'b0 || pending !== 2'd0) begin bad++; $display("FAIL single_drain got=%b/%0d exp=0/0", RegWrite, pending); end
  endtask

  task automatic test_load();
    offer(1'b1, 1'b1, 5'd9, 32'h0000_0001, 32'hDEAD_BEEF);
    tick();
    in_valid = 1'b0;
    total++; if (Din !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_din got=%h exp=deadbeef", Din); end
    total++; if (WA !== 5'd9 || RegWrite !== 1'b1) begin bad++; $display("FAIL load_wa got=%0d/%b exp=9/1", WA, RegWrite); end
    tick(); exp_ret++;
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL load_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask

  task automatic test_filter();
    offer(1'b1, 1'b0, 5'd0, 32'h1234, 32'h0);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL filter_zero_ready got=%b exp=1", in_ready); end
    tick();
    total++; if (RegWrite !== 1'b0 || pending !== 2'd0) begin bad++; $display("FAIL filter_zero got=%b/%0d exp=0/0", RegWrite, pending); end
    offer(1'b0, 1'b0, 5'd7, 32'h5678, 32'h0);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL filter_norw_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (RegWrite !== 1'b0 || pending !== 2'd0) begin bad++; $display("FAIL filter_norw got=%b/%0d exp=0/0", RegWrite, pending); end
    tick();
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL filter_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask

  task automatic test_stall_fill();
    rf_stall = 1'b1;
    offer(1'b1, 1'b0, 5'd1, 32'h11, 32'h0);
    tick();
    offer(1'b1, 1'b0, 5'd2, 32'h22, 32'h0);
    tick();
    in_valid = 1'b0;
    total++; if (pending !== 2'd2) begin bad++; $display("FAIL stall_pending got=%0d exp=2", pending); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    total++; if (RegWrite !== 1'b0 || WA !== 5'd1 || Din !== 32'h11) begin bad++; $display("FAIL stall_head got=%b/%0d/%h exp=0/1/11", RegWrite, WA, Din); end
    rf_stall = 1'b0;
    #1;
    total++; if (RegWrite !== 1'b1 || WA !== 5'd1 || Din !== 32'h11) begin bad++; $display("FAIL release_first got=%b/%0d/%h exp=1/1/11", RegWrite, WA, Din); end
    tick(); exp_ret++;
    total++; if (RegWrite !== 1'b1 || WA !== 5'd2 || Din !== 32'h22) begin bad++; $display("FAIL release_second got=%b/%0d/%h exp=1/2/22", RegWrite, WA, Din); end
    total++; if (in_ready !== 1'b1 || pending !== 2'd1) begin bad++; $display("FAIL release_ready got=%b/%0d exp=1/1", in_ready, pending); end
    tick(); exp_ret++;
    total++; if (pending !== 2'd0 || retired !== exp_ret) begin bad++; $display("FAIL release_drain got=%0d/%0d exp=0/%0d", pending, retired, exp_ret); end
  endtask

  task automatic test_bypass();
    rf_stall = 1'b1;
    offer(1'b1, 1'b0, 5'd3, 32'h33, 32'h0);
    tick();
    offer(1'b1, 1'b1, 5'd3, 32'h0, 32'h44);
    tick();
    in_valid = 1'b0;
    RA1 = 5'd3; RA2 = 5'd0;
    #1;
    total++; if (byp1_hit !== 1'b1 || byp1_data !== 32'h44) begin bad++; $display("FAIL byp_youngest got=%b/%h exp=1/44", byp1_hit, byp1_data); end
    total++; if (byp2_hit !== 1'b0 || byp2_data !== 32'h0) begin bad++; $display("FAIL byp_zero got=%b/%h exp=0/0", byp2_hit, byp2_data); end
    RA2 = 5'd2;
    #1;
    total++; if (byp2_hit !== 1'b0 || byp2_data !== 32'h0) begin bad++; $display("FAIL byp_miss got=%b/%h exp=0/0", byp2_hit, byp2_data); end
    rf_stall = 1'b0;
    #1;
    total++; if (RegWrite !== 1'b1 || byp1_hit !== 1'b1 || byp1_data !== 32'h44) begin bad++; $display("FAIL byp_pop_old got=%b/%b/%h exp=1/1/44", RegWrite, byp1_hit, byp1_data); end
    tick(); exp_ret++;
    total++; if (RegWrite !== 1'b1 || byp1_hit !== 1'b1 || byp1_data !== 32'h44) begin bad++; $display("FAIL byp_pop_last got=%b/%b/%h exp=1/1/44", RegWrite, byp1_hit, byp1_data); end
    tick(); exp_ret++;
    total++; if (byp1_hit !== 1'b0 || byp1_data !== 32'h0) begin bad++; $display("FAIL byp_empty got=%b/%h exp=0/0", byp1_hit, byp1_data); end
    RA1 = 5'd0; RA2 = 5'd0;
  endtask

  task automatic test_back_to_back();
    offer(1'b1, 1'b0, 5'd10, 32'hA10, 32'h0);
    tick();
    total++; if (pending !== 2'd1 || WA !== 5'd10) begin bad++; $display("FAIL b2b_first got=%0d/%0d exp=1/10", pending, WA); end
    offer(1'b1, 1'b0, 5'd11, 32'hA11, 32'h0);
    tick(); exp_ret++;
    total++; if (pending !== 2'd1 || WA !== 5'd11 || Din !== 32'hA11) begin bad++; $display("FAIL b2b_second got=%0d/%0d/%h exp=1/11/a11", pending, WA, Din); end
    offer(1'b1, 1'b0, 5'd12, 32'hA12, 32'h0);
    tick(); exp_ret++;
    in_valid = 1'b0;
    total++; if (pending !== 2'd1 || WA !== 5'd12 || Din !== 32'hA12) begin bad++; $display("FAIL b2b_third got=%0d/%0d/%h exp=1/12/a12", pending, WA, Din); end
    tick(); exp_ret++;
    total++; if (pending !== 2'd0 || retired !== exp_ret) begin bad++; $display("FAIL b2b_drain got=%0d/%0d exp=0/%0d", pending, retired, exp_ret); end
  endtask

  task automatic test_async_reset();
    rf_stall = 1'b1;
    offer(1'b1, 1'b0, 5'd6, 32'h66, 32'h0);
    tick();
    offer(1'b1, 1'b0, 5'd8, 32'h88, 32'h0);
    tick();
    in_valid = 1'b0;
    RA1 = 5'd8;
    rf_stall = 1'b0;
    #1;
    total++; if (pending !== 2'd2 || RegWrite !== 1'b1) begin bad++; $display("FAIL arst_pre got=%0d/%b exp=2/1", pending, RegWrite); end
    rst = 1'b1;
    #1;
    total++; if (RegWrite !== 1'b0 || pending !== 2'd0 || WA !== 5'd0) begin bad++; $display("FAIL arst_now got=%b/%0d/%0d exp=0/0/0", RegWrite, pending, WA); end
    total++; if (byp1_hit !== 1'b0 || retired !== 16'd0) begin bad++; $display("FAIL arst_byp got=%b/%0d exp=0/0", byp1_hit, retired); end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (RegWrite !== 1'b0 || pending !== 2'd0) begin bad++; $display("FAIL arst_stale%0d got=%b/%0d exp=0/0", i, RegWrite, pending); end
    end
    total++; if (retired !== 16'd0) begin bad++; $display("FAIL arst_retired got=%0d exp=0", retired); end
    RA1 = 5'd0;
  endtask

  initial begin
    in_valid = 1'b0; in_regwrite = 1'b0; in_memtoreg = 1'b0; in_wa = '0;
    in_alu = '0; in_mem = '0; rf_stall = 1'b0; RA1 = '0; RA2 = '0;
    test_reset();
    test_single();
    test_load();
    test_filter();
    test_stall_fill();
    test_bypass();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
